// File: rtl/demux_fifo_2ch.sv
// Two-channel capture buffer behind a 1-to-2 demux: the key steers each word into one of two FIFOs.
// Optional sticky overflow flags (ovf1/ovf2, ovf_clr) are compiled in with DEMUX_FIFO_OVF_FLAG_EN.

module demux_fifo_2ch_chan #(
    parameter int  WIDTH = 2,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_rd;
    logic             do_wr;
    logic [CW-1:0]    count_nxt;

    // A full channel still accepts a write when a read frees the head slot in the same cycle.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        do_rd     = rd && !empty;
        do_wr     = wr && (!full || do_rd);
        count_nxt = count;
        if (do_wr && !do_rd) begin
            count_nxt = count + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_nxt = count - CW'(1);
        end
    end

    // NOTE: storage is not reset; pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments, so a full-channel read sees the old head before the write lands.
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            empty   <= 1'b1;
            full    <= 1'b0;
        end else begin
            q_valid <= do_rd;
            if (do_rd) begin
                q    <= mem[rptr];
                rptr <= rptr + AW'(1);
            end
            if (do_wr) begin
                wptr <= wptr + AW'(1);
            end
            count <= count_nxt;
            empty <= (count_nxt == CW'(0));
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

endmodule

module demux_fifo_2ch #(
    parameter int  WIDTH = 2,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data,
    input  logic             key,
    input  logic             enable,
    input  logic             rd1,
    input  logic             rd2,
`ifdef DEMUX_FIFO_OVF_FLAG_EN
    input  logic             ovf_clr,
    output logic             ovf1,
    output logic             ovf2,
`endif
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic             q1_valid,
    output logic             q2_valid,
    output logic             empty1,
    output logic             empty2,
    output logic             full1,
    output logic             full2,
    output logic [CW-1:0]    count1,
    output logic [CW-1:0]    count2
);

    logic wr1;
    logic wr2;

    assign wr1 = enable && !key;
    assign wr2 = enable &&  key;

    demux_fifo_2ch_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch1 (
        .clock   (clock),
        .reset_n (reset_n),
        .wr      (wr1),
        .rd      (rd1),
        .din     (data),
        .q       (q1),
        .q_valid (q1_valid),
        .empty   (empty1),
        .full    (full1),
        .count   (count1)
    );

    demux_fifo_2ch_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch2 (
        .clock   (clock),
        .reset_n (reset_n),
        .wr      (wr2),
        .rd      (rd2),
        .din     (data),
        .q       (q2),
        .q_valid (q2_valid),
        .empty   (empty2),
        .full    (full2),
        .count   (count2)
    );

`ifdef DEMUX_FIFO_OVF_FLAG_EN
    logic drop1;
    logic drop2;

    // A write is dropped only when the channel is full and no read frees a slot that cycle.
    assign drop1 = wr1 && full1 && !(rd1 && !empty1);
    assign drop2 = wr2 && full2 && !(rd2 && !empty2);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ovf1 <= 1'b0;
            ovf2 <= 1'b0;
        end else begin
            if (drop1)        ovf1 <= 1'b1;
            else if (ovf_clr) ovf1 <= 1'b0;
            if (drop2)        ovf2 <= 1'b1;
            else if (ovf_clr) ovf2 <= 1'b0;
        end
    end
`endif

endmodule
